lcd_char_writer: RTL and testbench
==================================

// Module: lcd_char_writer
// PURPOSE
//   Downstream of the keypad/switch decoder. Takes 8-bit ASCII character codes
//   plus a one-cycle valid strobe and writes them to an HD44780-compatible 16x2
//   character LCD over an 8-bit write-only bus.
//   Runs the power-on init sequence, tracks the cursor, wraps line 1 -> line 2
//   -> clear, and exposes o_ready so the producer knows when a character is taken.
// PARAMETERS
//   PWR_CYC   750000  clk cycles to wait after reset before first command (15 ms @ 50 MHz)
//   E_PULSE   12      clk cycles lcd_e is held high per bus write (>=1)
//   CMD_WAIT  2500    clk cycles idle after E falls for normal cmd/data (50 us)
//   CLR_WAIT  100000  clk cycles idle after E falls for the 0x01 clear (2 ms)
//   COLS      16      characters per line (1..40)
// PORTS
//   clk           in   1  system clock, rising edge
//   rst           in   1  asynchronous, active-high reset
//   i_char_valid  in   1  one-cycle strobe: i_char is a character to display
//   i_char        in   8  ASCII code (e.g. 8'h30..8'h39 digits, 8'h20 blank)
//   i_clear       in   1  one-cycle strobe: clear display, home cursor
//   o_ready       out  1  1 = idle, a strobe this cycle is accepted
//   lcd_e         out  1  LCD enable
//   lcd_rs        out  1  LCD register select (0 = command, 1 = data)
//   lcd_rw        out  1  LCD read/write; tied 0 (write only)
//   lcd_data      out  8  LCD data bus
// BEHAVIOUR
//   Reset (async, any state, incl. mid-transaction):
//   - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, o_ready=0, cursor=(line0,col0).
//   - State = PWR_WAIT. A full init replays after every reset.
//   Bus transaction (one cmd/data byte):
//   - Cycle 0: drive rs and data, e=0.
//   - Cycles 1..E_PULSE: e=1.
//   - Then W cycles with e=0 and rs/data held. W = CLR_WAIT for cmd 0x01, else CMD_WAIT.
//   - Total length = 1 + E_PULSE + W cycles. rs/data never change while e=1.
//   FSM:
//   - PWR_WAIT (PWR_CYC cycles) -> FUNC 0x38 -> DISP 0x0C -> ENTRY 0x06 -> CLR 0x01 -> IDLE.
//   - IDLE: o_ready=1. Exactly one of the following occurs per accept edge:
//     - i_clear=1 -> CLEAR (0x01, rs=0). Cursor resets to (0,0).
//       i_clear wins over a simultaneous i_char_valid; that char is dropped.
//     - else i_char_valid=1 -> WRITE (i_char, rs=1). Then advance cursor:
//       - col<COLS-1: col+1 -> IDLE.
//       - col=COLS-1 on line0: SETADDR 0xC0 (rs=0, CMD_WAIT) -> (line1,col0) -> IDLE.
//       - col=COLS-1 on line1: CLEAR 0x01 (CLR_WAIT) -> (line0,col0) -> IDLE.
//   - o_ready falls the cycle after an accept edge. It rises the cycle after the
//     last wait cycle of the final transaction.
//   - Strobes while o_ready=0 are ignored; no buffering.
//   - i_char is sampled only on the accept edge; later changes have no effect.
//   - Wait counters are wide enough for max(PWR_CYC, CLR_WAIT) with no wrap.
//   - The cursor is internal; the LCD's own auto-increment (entry mode 0x06)
//     keeps the two in step.
// TESTING  (bench params: PWR_CYC=10, E_PULSE=2, CMD_WAIT=4, CLR_WAIT=8)
//   1 Release rst -> first e rise 11 cycles later. rs=0 writes 0x38,0x0C,0x06,0x01
//     in order, each with e high exactly 2 cycles. o_ready=1 after the 0x01 wait (8).
//   2 In IDLE, i_char_valid with 8'h35 -> one rs=1 write of 0x35. o_ready low for
//     exactly 7 cycles. A strobe during that window produces no bus activity.
//   3 Write 16 chars '0'..'9','0'..'5' -> after the 16th, one rs=0 write of 0xC0
//     before o_ready returns. The 17th char is a plain data write.
//   4 Write 32 chars -> after the 32nd, rs=0 0x01 with an 8-cycle wait. The 33rd
//     char is written with no preceding 0xC0, and 0xC0 recurs after 16 more chars.
//   5 i_clear and i_char_valid (8'h37) on the same cycle -> only 0x01 appears on
//     the bus. The next 0xC0 occurs after 16 further chars.
//   6 Assert rst while e=1 mid-write -> e=0, data=00, o_ready=0 immediately.
//     After release, the full init of scenario 1 replays.

Source files
------------

// File: rtl/lcd_char_writer.sv
// HD44780 16x2 writer: power-on init, then one character per accepted strobe, with cursor wrap.
// Busy for one full bus transaction (1 + E_PULSE + wait) per byte; o_ready low means strobes are dropped, never queued.
module lcd_char_writer #(
    parameter int PWR_CYC  = 750000,
    parameter int E_PULSE  = 12,
    parameter int CMD_WAIT = 2500,
    parameter int CLR_WAIT = 100000,
    parameter int COLS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_char_valid,
    input  logic [7:0] i_char,
    input  logic       i_clear,
    output logic       o_ready,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int MAX_A   = (PWR_CYC > CLR_WAIT) ? PWR_CYC : CLR_WAIT;
    localparam int MAX_B   = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int COLW    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_PWR,
        S_FUNC,
        S_DISP,
        S_ENTRY,
        S_IDLE,
        S_WRITE,
        S_SETADDR,
        S_CLEAR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_E,
        PH_WAIT
    } phase_t;

    state_t            state, state_d;
    phase_t            phase, phase_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              rs_q, rs_d;
    logic [7:0]        data_q, data_d;
    logic              line_q, line_d;
    logic [COLW-1:0]   col_q, col_d;
    logic [CW-1:0]     wait_last;

    logic              go;
    state_t            go_state;
    logic              go_rs;
    logic [7:0]        go_data;

    // The clear command needs the long settle time; everything else uses the short one.
    assign wait_last = (!rs_q && data_q == 8'h01) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_PWR;
            phase  <= PH_SETUP;
            cnt    <= '0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            line_q <= 1'b0;
            col_q  <= '0;
        end else begin
            state  <= state_d;
            phase  <= phase_d;
            cnt    <= cnt_d;
            rs_q   <= rs_d;
            data_q <= data_d;
            line_q <= line_d;
            col_q  <= col_d;
        end
    end

    always_comb begin
        state_d  = state;
        phase_d  = phase;
        cnt_d    = cnt;
        rs_d     = rs_q;
        data_d   = data_q;
        line_d   = line_q;
        col_d    = col_q;
        go       = 1'b0;
        go_state = S_IDLE;
        go_rs    = 1'b0;
        go_data  = 8'h00;

        case (state)
            S_PWR: begin
                if (cnt == CW'(PWR_CYC - 1)) begin
                    go       = 1'b1;
                    go_state = S_FUNC;
                    go_data  = 8'h38;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_IDLE: begin
                // Clear has priority; a character strobed alongside it is dropped.
                if (i_clear) begin
                    go       = 1'b1;
                    go_state = S_CLEAR;
                    go_data  = 8'h01;
                end else if (i_char_valid) begin
                    go       = 1'b1;
                    go_state = S_WRITE;
                    go_rs    = 1'b1;
                    go_data  = i_char;
                end
            end
            default: begin
                case (phase)
                    PH_SETUP: begin
                        phase_d = PH_E;
                        cnt_d   = '0;
                    end
                    PH_E: begin
                        if (cnt == CW'(E_PULSE - 1)) begin
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end
                    default: begin
                        if (cnt != wait_last) begin
                            cnt_d = cnt + CW'(1);
                        end else begin
                            case (state)
                                S_FUNC: begin
                                    go       = 1'b1;
                                    go_state = S_DISP;
                                    go_data  = 8'h0C;
                                end
                                S_DISP: begin
                                    go       = 1'b1;
                                    go_state = S_ENTRY;
                                    go_data  = 8'h06;
                                end
                                S_ENTRY: begin
                                    go       = 1'b1;
                                    go_state = S_CLEAR;
                                    go_data  = 8'h01;
                                end
                                S_WRITE: begin
                                    // The LCD auto-increments; only line ends need an explicit command.
                                    if (col_q != COLW'(COLS - 1)) begin
                                        col_d   = col_q + COLW'(1);
                                        state_d = S_IDLE;
                                    end else if (!line_q) begin
                                        go       = 1'b1;
                                        go_state = S_SETADDR;
                                        go_data  = 8'hC0;
                                    end else begin
                                        go       = 1'b1;
                                        go_state = S_CLEAR;
                                        go_data  = 8'h01;
                                    end
                                end
                                S_SETADDR: begin
                                    line_d  = 1'b1;
                                    col_d   = '0;
                                    state_d = S_IDLE;
                                end
                                default: begin
                                    line_d  = 1'b0;
                                    col_d   = '0;
                                    state_d = S_IDLE;
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase

        if (go) begin
            state_d = go_state;
            phase_d = PH_SETUP;
            cnt_d   = '0;
            rs_d    = go_rs;
            data_d  = go_data;
        end
    end

    assign o_ready  = (state == S_IDLE);
    assign lcd_e    = (phase == PH_E);
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: random characters against a linear-cursor model of the expected bus traffic.
module tb_lcd_char_writer;
    localparam int PWR_CYC  = 10;
    localparam int E_PULSE  = 2;
    localparam int CMD_WAIT = 4;
    localparam int CLR_WAIT = 8;
    localparam int COLS     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_char_valid = 1'b0;
    logic       i_clear = 1'b0;
    logic [7:0] i_char = 8'h00;
    logic       o_ready, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int checks = 0;
    int failures = 0;
    int hold_err = 0;
    int m_pos = 0;
    int mon_q[$];

    always #5 clk = ~clk;

    lcd_char_writer #(
        .PWR_CYC(PWR_CYC), .E_PULSE(E_PULSE), .CMD_WAIT(CMD_WAIT),
        .CLR_WAIT(CLR_WAIT), .COLS(COLS)
    ) dut (
        .clk(clk), .rst(rst), .i_char_valid(i_char_valid), .i_char(i_char),
        .i_clear(i_clear), .o_ready(o_ready), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    function automatic int txn_code(logic rs, int el, logic [7:0] d);
        return {19'd0, rs, el[3:0], d};
    endfunction

    function automatic int txn_len(logic rs, logic [7:0] d);
        return 1 + E_PULSE + ((!rs && d == 8'h01) ? CLR_WAIT : CMD_WAIT);
    endfunction

    // Bus monitor: one record per completed E pulse, with rs/data/E-length.
    logic       e_prev = 1'b0;
    int         e_len = 0;
    logic       rec_rs = 1'b0;
    logic [7:0] rec_d = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            e_prev = 1'b0;
        end else begin
            if (lcd_e && !e_prev) begin
                rec_rs = lcd_rs;
                rec_d  = lcd_data;
                e_len  = 1;
            end else if (lcd_e) begin
                e_len++;
                if (lcd_rs !== rec_rs || lcd_data !== rec_d) hold_err++;
            end else if (e_prev) begin
                mon_q.push_back(txn_code(rec_rs, e_len, rec_d));
            end
            e_prev = lcd_e;
        end
    end

    task automatic model_emit(input logic rs, input logic [7:0] d,
                              inout logic [63:0] s, inout int b);
        s = (s << 16) | 64'(txn_code(rs, E_PULSE, d));
        b += txn_len(rs, d);
    endtask

    // Cursor as a linear position 0..2*COLS-1 on the two-line screen.
    task automatic model_op(input bit clr, input logic [7:0] c,
                            output logic [63:0] s, output int b);
        s = '0;
        b = 0;
        if (clr) begin
            model_emit(1'b0, 8'h01, s, b);
            m_pos = 0;
        end else begin
            model_emit(1'b1, c, s, b);
            m_pos++;
            if (m_pos == COLS) begin
                model_emit(1'b0, 8'hC0, s, b);
            end else if (m_pos == 2 * COLS) begin
                model_emit(1'b0, 8'h01, s, b);
                m_pos = 0;
            end
        end
    endtask

    function automatic logic [63:0] drain_mon();
        logic [63:0] s = '0;
        while (mon_q.size() > 0) s = (s << 16) | 64'(mon_q.pop_front());
        return s;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_ready timeout o_ready=%b expected 1", o_ready);
        end
    endtask

    // Drives one accepted strobe, optionally pokes while busy, returns busy length and bus traffic.
    task automatic do_op(input bit clr, input bit chr, input logic [7:0] c, input bit poke,
                         output int busy, output logic [63:0] sig);
        wait_ready();
        i_clear      = clr;
        i_char_valid = chr;
        i_char       = c;
        @(negedge clk);
        i_clear      = 1'b0;
        i_char_valid = 1'b0;
        i_char       = 8'($urandom);
        busy = 0;
        while (!o_ready && busy < 1000) begin
            busy++;
            if (poke && busy == 2) begin
                i_char_valid = 1'b1;
                i_clear      = 1'($urandom);
                i_char       = 8'($urandom_range(126, 32));
            end else begin
                i_char_valid = 1'b0;
                i_clear      = 1'b0;
            end
            @(negedge clk);
        end
        i_char_valid = 1'b0;
        i_clear      = 1'b0;
        sig = drain_mon();
    endtask

    task automatic test_reset();
        int n = 0;
        int first_e = 0;
        int eb = 0;
        logic [63:0] es = '0;
        logic [63:0] os;
        rst = 1'b1;
        i_char_valid = 1'b0;
        i_clear = 1'b0;
        @(negedge clk);
        checks++;
        if ({lcd_e, lcd_rs, lcd_rw, o_ready, lcd_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got e=%b rs=%b rw=%b rdy=%b data=%h expected all 0",
                     lcd_e, lcd_rs, lcd_rw, o_ready, lcd_data);
        end
        mon_q.delete();
        m_pos = 0;
        hold_err = 0;
        rst = 1'b0;
        while (!o_ready && n < 1000) begin
            @(negedge clk);
            n++;
            if (lcd_e && first_e == 0) first_e = n;
        end
        model_emit(1'b0, 8'h38, es, eb);
        model_emit(1'b0, 8'h0C, es, eb);
        model_emit(1'b0, 8'h06, es, eb);
        model_emit(1'b0, 8'h01, es, eb);
        os = drain_mon();
        checks++;
        if (first_e !== PWR_CYC + 1) begin
            failures++;
            $display("FAIL init_first_e got=%0d expected=%0d", first_e, PWR_CYC + 1);
        end
        checks++;
        if (n !== PWR_CYC + eb) begin
            failures++;
            $display("FAIL init_ready_time got=%0d expected=%0d", n, PWR_CYC + eb);
        end
        checks++;
        if (os !== es) begin
            failures++;
            $display("FAIL init_sequence got=%h expected=%h", os, es);
        end
        checks++;
        if (hold_err !== 0) begin
            failures++;
            $display("FAIL init_hold got=%0d expected=0", hold_err);
        end
    endtask

    task automatic test_char_write();
        int busy, eb;
        logic [63:0] sig, es;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] c = (i == 0) ? 8'h35 : 8'($urandom_range(126, 32));
            do_op(1'b0, 1'b1, c, 1'b1, busy, sig);
            model_op(1'b0, c, es, eb);
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL char_busy[%0d] got=%0d expected=%0d", i, busy, eb);
            end
            checks++;
            if (sig !== es) begin
                failures++;
                $display("FAIL char_bus[%0d] got=%h expected=%h", i, sig, es);
            end
        end
    endtask

    task automatic test_line_wrap();
        int busy, eb;
        logic [63:0] sig, es;
        for (int i = 0; i < 18; i++) begin
            bit clr = (i == 0);
            logic [7:0] c = (i >= 1 && i <= 16) ? 8'(8'h30 + (i - 1) % 10) : 8'($urandom_range(126, 32));
            do_op(clr, !clr, c, 1'($urandom), busy, sig);
            model_op(clr, c, es, eb);
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL line_busy[%0d] got=%0d expected=%0d", i, busy, eb);
            end
            checks++;
            if (sig !== es) begin
                failures++;
                $display("FAIL line_bus[%0d] got=%h expected=%h", i, sig, es);
            end
        end
    endtask

    task automatic test_screen_wrap();
        int busy, eb;
        logic [63:0] sig, es;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] c = 8'($urandom_range(126, 32));
            do_op(1'b0, 1'b1, c, 1'($urandom), busy, sig);
            model_op(1'b0, c, es, eb);
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL screen_busy[%0d] got=%0d expected=%0d", i, busy, eb);
            end
            checks++;
            if (sig !== es) begin
                failures++;
                $display("FAIL screen_bus[%0d] got=%h expected=%h", i, sig, es);
            end
        end
        checks++;
        if (hold_err !== 0) begin
            failures++;
            $display("FAIL screen_hold got=%0d expected=0", hold_err);
        end
    endtask

    task automatic test_clear_priority();
        int busy, eb;
        logic [63:0] sig, es;
        for (int i = 0; i < 17; i++) begin
            bit clr = (i == 0);
            logic [7:0] c = clr ? 8'h37 : 8'($urandom_range(126, 32));
            do_op(clr, 1'b1, c, 1'b0, busy, sig);
            model_op(clr, c, es, eb);
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL prio_busy[%0d] got=%0d expected=%0d", i, busy, eb);
            end
            checks++;
            if (sig !== es) begin
                failures++;
                $display("FAIL prio_bus[%0d] got=%h expected=%h", i, sig, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int busy, eb;
        logic [63:0] sig, es;
        wait_ready();
        i_char_valid = 1'b1;
        i_char       = 8'h41;
        @(negedge clk);
        i_char_valid = 1'b0;
        while (!lcd_e && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({lcd_e, o_ready, lcd_data} !== 10'h000) begin
            failures++;
            $display("FAIL mid_reset got e=%b rdy=%b data=%h expected e=0 rdy=0 data=00",
                     lcd_e, o_ready, lcd_data);
        end
        test_reset();
        for (int i = 0; i < COLS; i++) begin
            logic [7:0] c = 8'($urandom_range(126, 32));
            do_op(1'b0, 1'b1, c, 1'b0, busy, sig);
            model_op(1'b0, c, es, eb);
            checks++;
            if (sig !== es) begin
                failures++;
                $display("FAIL post_reset_bus[%0d] got=%h expected=%h", i, sig, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_char_write();
        test_line_wrap();
        test_screen_wrap();
        test_clear_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete, expected completion before 1ms");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
